hongwai: RTL and testbench

HONGWAI -- requirements
Module: hongwai

---
 rtl/hongwai.sv | 166 ++++++++++++++++
 tb/tb_hongwai.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hongwai.sv
// ----------------------------------------------------------------------------
// hongwai : NEC-style IR transmitter, 35-bit + 32-bit frame on a key press.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hongwai #(
  parameter int CLK_PER_US  = 50,
  parameter int CARRIER_DIV = 1316
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_1,
  input  logic [34:0] IR_in_data35,
  input  logic [31:0] IR_in_data32,
  output logic        IR_out,
  output logic        led_out
);

  localparam int CW = $clog2(20000 * CLK_PER_US) + 1;
  localparam int PW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  localparam logic [CW-1:0] T_LEAD_MARK  = CW'(9000 * CLK_PER_US);
  localparam logic [CW-1:0] T_LEAD_SPACE = CW'(4500 * CLK_PER_US);
  localparam logic [CW-1:0] T_MARK       = CW'(560 * CLK_PER_US);
  localparam logic [CW-1:0] T_ZERO       = CW'(560 * CLK_PER_US);
  localparam logic [CW-1:0] T_ONE        = CW'(1690 * CLK_PER_US);
  localparam logic [CW-1:0] T_CONN_SPACE = CW'(20000 * CLK_PER_US);
  localparam logic [PW-1:0] C_CAR_LAST   = PW'(CARRIER_DIV - 1);
  localparam logic [PW-1:0] C_CAR_HALF   = PW'(CARRIER_DIV / 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK,
    S_BIT_SPACE, S_CONN_MARK, S_CONN_SPACE, S_END_MARK
  } state_t;

  state_t          state_q, state_d;
  logic            key_s1_q, key_s1_d, key_s2_q, key_s2_d, key_s3_q, key_s3_d;
  logic [1:0]      vld_q, vld_d;
  logic            armed_q, armed_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [5:0]      bit_q, bit_d;
  logic            field_q, field_d;
  logic [34:0]     d35_q, d35_d;
  logic [31:0]     d32_q, d32_d;
  logic [PW-1:0]   car_q, car_d;
  logic            ir_q, ir_d;
  logic            led_q, led_d;

  logic            start, cur_bit, last_bit, done, mark;
  logic [CW-1:0]   dur;

  always_comb begin
    key_s1_d = key_1;
    key_s2_d = key_s1_q;
    key_s3_d = key_s2_q;
    // Arming needs a real low sample after reset, so a key held through reset cannot fire.
    vld_d    = {vld_q[0], 1'b1};
    armed_d  = armed_q | (vld_q[1] & ~key_s2_q);
    start    = armed_q & key_s2_q & ~key_s3_q;

    car_d    = (car_q == C_CAR_LAST) ? '0 : car_q + 1'b1;

    cur_bit  = field_q ? d32_q[0] : d35_q[0];
    last_bit = field_q ? (bit_q == 6'd31) : (bit_q == 6'd34);

    case (state_q)
      S_LEAD_MARK:  dur = T_LEAD_MARK;
      S_LEAD_SPACE: dur = T_LEAD_SPACE;
      S_BIT_SPACE:  dur = cur_bit ? T_ONE : T_ZERO;
      S_CONN_SPACE: dur = T_CONN_SPACE;
      default:      dur = T_MARK;
    endcase
    done = (cnt_q == dur - 1'b1);

    state_d = state_q;
    bit_d   = bit_q;
    field_d = field_q;
    d35_d   = d35_q;
    d32_d   = d32_q;
    cnt_d   = (state_q == S_IDLE || done) ? '0 : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LEAD_MARK;
          d35_d   = IR_in_data35;
          d32_d   = IR_in_data32;
          bit_d   = '0;
          field_d = 1'b0;
        end
      end
      S_LEAD_MARK:  if (done) state_d = S_LEAD_SPACE;
      S_LEAD_SPACE: if (done) state_d = S_BIT_MARK;
      S_BIT_MARK:   if (done) state_d = S_BIT_SPACE;
      S_BIT_SPACE: begin
        if (done) begin
          // Payload shifts right so bit 0 is always the one on air.
          if (field_q) d32_d = {1'b0, d32_q[31:1]};
          else         d35_d = {1'b0, d35_q[34:1]};
          if (last_bit) begin
            bit_d   = '0;
            state_d = field_q ? S_END_MARK : S_CONN_MARK;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = S_BIT_MARK;
          end
        end
      end
      S_CONN_MARK:  if (done) state_d = S_CONN_SPACE;
      S_CONN_SPACE: begin
        if (done) begin
          state_d = S_BIT_MARK;
          field_d = 1'b1;
        end
      end
      S_END_MARK:   if (done) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase

    mark  = (state_q == S_LEAD_MARK) || (state_q == S_BIT_MARK) ||
            (state_q == S_CONN_MARK) || (state_q == S_END_MARK);
    ir_d  = mark & (car_q < C_CAR_HALF);
    led_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      key_s1_q <= 1'b0;
      key_s2_q <= 1'b0;
      key_s3_q <= 1'b0;
      vld_q    <= '0;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      field_q  <= 1'b0;
      d35_q    <= '0;
      d32_q    <= '0;
      car_q    <= '0;
      ir_q     <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
      key_s3_q <= key_s3_d;
      vld_q    <= vld_d;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      field_q  <= field_d;
      d35_q    <= d35_d;
      d32_q    <= d32_d;
      car_q    <= car_d;
      ir_q     <= ir_d;
      led_q    <= led_d;
    end
  end

  assign IR_out  = ir_q;
  assign led_out = led_q;

endmodule

`default_nettype wire

// File: tb/tb_hongwai.sv
// ----------------------------------------------------------------------------
// tb_hongwai : directed self-checking bench for hongwai (CLK_PER_US=1, CARRIER_DIV=4).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hongwai;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_1 = 1'b0;
  logic [34:0] IR_in_data35 = '0;
  logic [31:0] IR_in_data32 = '0;
  logic        IR_out;
  logic        led_out;

  int n_chk = 0;
  int n_fail = 0;
  bit ir_log [0:160000];

  hongwai #(.CLK_PER_US(1), .CARRIER_DIV(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_1        (key_1),
    .IR_in_data35 (IR_in_data35),
    .IR_in_data32 (IR_in_data32),
    .IR_out       (IR_out),
    .led_out      (led_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Count negedges until led_out rises; caller raised key_1 at a negedge.
  task automatic wait_led(output int lat);
    lat = 0;
    while (!led_out && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Log IR_out from the first led_out-high cycle; IR_out trails the state by one cycle.
  task automatic capture(output int len);
    len = 0;
    while (led_out && len < 160000) begin
      ir_log[len] = IR_out;
      len++;
      @(negedge clk);
    end
    ir_log[len] = IR_out;
  endtask

  function automatic int highs(input int a, input int b);
    int n = 0;
    for (int t = a; t <= b; t++) n += int'(ir_log[t]);
    return n;
  endfunction

  function automatic int alt_err(input int a, input int b);
    int n = 0;
    for (int t = a; t <= b - 2; t++) if (ir_log[t] == ir_log[t+2]) n++;
    return n;
  endfunction

  task automatic quiet_cycles(input int n, output int active);
    active = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (led_out || IR_out) active++;
    end
  endtask

  localparam logic [34:0] P35 = 35'b11111000001111100000111110000011111;
  localparam logic [31:0] P32 = 32'b11111000001111100000111110000011;

  initial begin
    int lat, len, act, lows;

    // Reset held while key toggles
    act = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      key_1 = ~key_1;
      if (led_out || IR_out) act++;
    end
    chk("reset_quiet", act, 0);

    // Key already high at reset release must not start a frame
    @(negedge clk);
    key_1 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    quiet_cycles(30, act);
    chk("no_start_key_held", act, 0);
    key_1 = 1'b0;
    repeat (6) @(negedge clk);

    // Frame 1 with mid-frame payload change and key re-presses
    IR_in_data35 = P35;
    IR_in_data32 = P32;
    key_1 = 1'b1;
    wait_led(lat);
    chk("start_latency", lat, 3);
    fork
      capture(len);
      begin
        repeat (2000) @(negedge clk);
        IR_in_data35 = 35'h0_1234_5678;
        IR_in_data32 = 32'h0;
        key_1 = 1'b0;
        repeat (3) @(negedge clk);
        key_1 = 1'b1;
        repeat (3) @(negedge clk);
        key_1 = 1'b0;
        repeat (98000) @(negedge clk);
        IR_in_data35 = '0;
        IR_in_data32 = 32'hFFFF_FFFF;
        key_1 = 1'b1;
        repeat (5) @(negedge clk);
        key_1 = 1'b0;
      end
    join
    chk("frame_len", len, 151470);
    chk("lead_mark_highs", highs(1, 9000), 4500);
    chk("lead_mark_carrier", alt_err(1, 9000), 0);
    chk("lead_space_highs", highs(9001, 13500), 0);
    chk("bit0_mark_highs", highs(13501, 14060), 280);
    chk("bit0_space_one", highs(14061, 15750), 0);
    chk("bit1_mark_start", highs(15751, 15754), 2);
    chk("conn_mark_highs", highs(75301, 75860), 280);
    chk("conn_space_highs", highs(75861, 95860), 0);
    chk("end_mark_highs", highs(len - 559, len), 280);
    chk("frame_total_highs", highs(0, len), 23820);
    quiet_cycles(50, act);
    chk("idle_after_frame", act, 0);

    // Frame 2 aborted by reset during DATA32
    IR_in_data35 = '0;
    IR_in_data32 = '0;
    @(negedge clk);
    key_1 = 1'b1;
    wait_led(lat);
    chk("start_latency_2", lat, 3);
    lows = 0;
    for (int i = 0; i < 80000; i++) begin
      @(negedge clk);
      if (i == 10) key_1 = 1'b0;
      if (!led_out) lows++;
    end
    chk("led_held_frame2", lows, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_led", led_out, 0);
    chk("abort_ir", IR_out, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    quiet_cycles(50, act);
    chk("idle_after_abort", act, 0);

    // Frame 3, all-zero payload after abort
    key_1 = 1'b1;
    wait_led(lat);
    chk("start_latency_3", lat, 3);
    capture(len);
    key_1 = 1'b0;
    chk("zero_frame_len", len, 109660);
    chk("zero_total_highs", highs(0, len), 23820);
    chk("zero_bit0_space", highs(14061, 14620), 0);
    chk("zero_bit1_mark_start", highs(14621, 14624), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #(10 * 600000);
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
